// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MS_BIT = 6;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;

  // Address after a data byte: auto-increment wraps naturally at the 6-bit boundary.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic              ms);
    return ms ? addr + ADDR_W'(1) : addr;
  endfunction

endpackage

// File: rtl/spi_slave_regs_if.sv
// Single-cycle register bus between the SPI responder (master side) and the host register file.
interface spi_slave_regs_if;
  import spi_pkg::*;

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with a history flop for edge detection.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   hist;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_chain <= {SYNC_STAGES{RST_VAL}};
      hist       <= RST_VAL;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], pin};
      hist       <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign level = sync_chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-3 responder translating command/data bytes into single-cycle register bus accesses.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    spi_sck,
  input  logic                    spi_csn,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic                    spi_miso_oe,
  output logic                    active,
  spi_slave_regs_if.master        bus
);

  logic sck_lvl, sck_rise, sck_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk_in(clk_in), .rst(rst), .pin(spi_sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk_in(clk_in), .rst(rst), .pin(spi_csn),
    .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .rst(rst), .pin(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_lvl, csn_lvl, mosi_rise, mosi_fall};

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_byte;
  logic              rw;
  logic              ms;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic              re_p1;
  logic [2:0]        settle_cnt;

  assign rx_byte = {rx_shift[DATA_W-2:0], mosi_lvl};

  // A CSn that is already low when reset releases shows up as a spurious fall while the
  // synchronizer flushes; settle_cnt masks that window so only a fresh fall starts a transfer.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      active      <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      re_p1       <= 1'b0;
      rw          <= 1'b0;
      ms          <= 1'b0;
      settle_cnt  <= 3'(SYNC_STAGES + 1);
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_p1  <= reg_re;
      if (settle_cnt != 3'd0) settle_cnt <= settle_cnt - 3'd1;

      if (state != IDLE && csn_rise) begin
        state       <= IDLE;
        active      <= 1'b0;
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (csn_fall && settle_cnt == 3'd0) begin
              state       <= CMD;
              bit_cnt     <= 3'd0;
              active      <= 1'b1;
              spi_miso_oe <= 1'b1;
              spi_miso    <= 1'b0;
              tx_shift    <= '0;
            end
          end

          CMD: begin
            if (sck_rise) begin
              rx_shift <= rx_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= rx_byte[CMD_RW_BIT];
                ms    <= rx_byte[CMD_MS_BIT];
                addr  <= rx_byte[ADDR_W-1:0];
                state <= DATA;
                if (rx_byte[CMD_RW_BIT]) begin
                  reg_re   <= 1'b1;
                  reg_addr <= rx_byte[ADDR_W-1:0];
                end else begin
                  tx_shift <= '0;
                end
              end
            end else if (sck_fall) begin
              spi_miso <= 1'b0;
            end
          end

          DATA: begin
            if (sck_rise) begin
              rx_shift <= rx_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= next_addr(addr, ms);
                if (rw) begin
                  reg_re   <= 1'b1;
                  reg_addr <= next_addr(addr, ms);
                end else begin
                  reg_we    <= 1'b1;
                  reg_addr  <= addr;
                  reg_wdata <= rx_byte;
                end
              end
            end else if (sck_fall) begin
              spi_miso <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            // Host read data arrives the cycle after reg_re and seeds the next outgoing byte.
            if (re_p1) tx_shift <= bus.reg_rdata;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.reg_addr  = reg_addr;
  assign bus.reg_wdata = reg_wdata;
  assign bus.reg_we    = reg_we;
  assign bus.reg_re    = reg_re;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Scoreboard bench: SPI master model plus host register file, expected bus strobes and MISO bytes queued.
module tb_spi_slave_regs;

  localparam int HALF = 6;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic spi_sck  = 1'b1;
  logic spi_csn  = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic spi_miso_oe;
  logic active;

  spi_slave_regs_if bus ();

  spi_slave_regs #(.SYNC_STAGES(2)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .active      (active),
    .bus         (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [5:0] exp_rd[$];
  logic [7:0] exp_miso[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] host_rd(input logic [5:0] a);
    return (a == 6'h0F) ? 8'h33 : ({2'b00, a} ^ 8'hA5);
  endfunction

  // Host register file: read data presented the cycle after reg_re.
  always @(posedge clk_in)
    if (bus.reg_re) bus.reg_rdata <= host_rd(bus.reg_addr);

  always @(negedge clk_in) begin : mon
    wr_t        w;
    logic [5:0] r;
    if (bus.reg_we) begin
      if (exp_wr.size() == 0) check("we_unexpected", 32'(bus.reg_we), 0);
      else begin
        w = exp_wr.pop_front();
        check("we_addr", 32'(bus.reg_addr), 32'(w.addr));
        check("we_data", 32'(bus.reg_wdata), 32'(w.data));
      end
    end
    if (bus.reg_re) begin
      if (exp_rd.size() == 0) check("re_unexpected", 32'(bus.reg_re), 0);
      else begin
        r = exp_rd.pop_front();
        check("re_addr", 32'(bus.reg_addr), 32'(r));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = tx[i];
      wait_clks(HALF);
      rx[i]   = spi_miso;
      spi_sck = 1'b1;
      wait_clks(HALF);
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    logic [7:0] rx;
    logic [7:0] e;
    spi_bits(b, 8, rx);
    if (exp_miso.size() == 0) check("miso_unexpected", 32'(rx), 32'hFFFF_FFFF);
    else begin
      e = exp_miso.pop_front();
      check("miso_byte", 32'(rx), 32'(e));
    end
  endtask

  task automatic run_txn(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bs[4];
    bs = '{b0, b1, b2, b3};
    spi_csn = 1'b0;
    wait_clks(HALF);
    check("active_on", 32'(active), 1);
    check("miso_oe_on", 32'(spi_miso_oe), 1);
    for (int i = 0; i < n; i++) xfer(bs[i]);
    wait_clks(HALF);
    spi_csn = 1'b1;
    wait_clks(2 * HALF);
    check("active_off", 32'(active), 0);
    check("miso_oe_off", 32'(spi_miso_oe), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},    32'(spi_miso), 0);
    check({tag, "_miso_oe"}, 32'(spi_miso_oe), 0);
    check({tag, "_addr"},    32'(bus.reg_addr), 0);
    check({tag, "_wdata"},   32'(bus.reg_wdata), 0);
    check({tag, "_we"},      32'(bus.reg_we), 0);
    check({tag, "_re"},      32'(bus.reg_re), 0);
    check({tag, "_active"},  32'(active), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rx;
    wait_clks(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(8);

    // WHO_AM_I read, ms=0: command re plus a trailing prefetch at the same address.
    exp_rd.push_back(6'h0F);
    exp_rd.push_back(6'h0F);
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h33);
    run_txn(2, 8'h8F, 8'h00, 8'h00, 8'h00);

    // Single write.
    exp_wr.push_back('{addr: 6'h20, data: 8'h57});
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    run_txn(2, 8'h20, 8'h57, 8'h00, 8'h00);

    // Burst read with auto-increment.
    exp_rd.push_back(6'h28);
    exp_rd.push_back(6'h29);
    exp_rd.push_back(6'h2A);
    exp_rd.push_back(6'h2B);
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h8D);
    exp_miso.push_back(8'h8C);
    exp_miso.push_back(8'h8F);
    run_txn(4, 8'hE8, 8'hFF, 8'hFF, 8'hFF);

    // Address wrap 0x3F -> 0x00 on burst write.
    exp_wr.push_back('{addr: 6'h3F, data: 8'h11});
    exp_wr.push_back('{addr: 6'h00, data: 8'h22});
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    run_txn(3, 8'h7F, 8'h11, 8'h22, 8'h00);

    // Abort after four data bits: partial byte must not write.
    spi_csn = 1'b0;
    wait_clks(HALF);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'hC3, 4, rx);
    spi_csn = 1'b1;
    wait_clks(2 * HALF);
    check("abort_active", 32'(active), 0);
    exp_wr.push_back('{addr: 6'h21, data: 8'h05});
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    run_txn(2, 8'h21, 8'h05, 8'h00, 8'h00);

    // Reset in the middle of a write burst while CSn stays low.
    spi_csn = 1'b0;
    wait_clks(HALF);
    spi_bits(8'h60, 8, rx);
    spi_bits(8'hAA, 3, rx);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check_reset_outputs("midrst");
    spi_bits(8'h12, 8, rx);
    spi_bits(8'h34, 8, rx);
    check("midrst_idle_active", 32'(active), 0);
    check("midrst_idle_oe", 32'(spi_miso_oe), 0);
    spi_csn = 1'b1;
    wait_clks(2 * HALF);
    exp_wr.push_back('{addr: 6'h21, data: 8'h66});
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    run_txn(2, 8'h21, 8'h66, 8'h00, 8'h00);

    wait_clks(4);
    check("wr_pending", 32'(exp_wr.size()), 0);
    check("rd_pending", 32'(exp_rd.size()), 0);
    check("miso_pending", 32'(exp_miso.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
